// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry {instr, pc} prefetch queue.
// A redirect flushes the queue and in-flight fetches, then restarts at the new PC.
module fetch_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [INSTR_W-1:0]         mem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0]  instr_q [DEPTH];
  logic [INSTR_W-1:0]  instr_d [DEPTH];
  logic [ADDR_W-1:0]   pc_q    [DEPTH];
  logic [ADDR_W-1:0]   pc_d    [DEPTH];

  logic                push;
  logic                pop;
  logic [ADDR_W-1:0]   pc_inc;

  always_comb begin
    push     = req_q && mem_ack && (state_q == REQ) && !redirect_valid;
    pop      = (count_q != '0) && out_ready && !redirect_valid;
    pc_inc   = fetch_pc_q + STEP_C;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    count_d    = count_q + CW'(push) - CW'(pop);

    if (push) begin
      instr_d[wr_ptr_q] = mem_rdata;
      pc_d[wr_ptr_q]    = addr_q;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Redirect overrides any same-cycle push/pop: the queue restarts empty.
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (count_d < DEPTH_C) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = mem_ack ? IDLE : FLUSH;
        end else if (mem_ack) begin
          fetch_pc_d = pc_inc;
          if (count_d < DEPTH_C) begin
            addr_d = pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // The stale request must still complete; its data is never queued.
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d == REQ) || (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a wait-state memory model.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [2:0]  occupancy;

  int checks;
  int errors;
  int wait_n;
  int wcnt;
  logic force_ack;

  fetch_prefetch_queue #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .DEPTH   (4),
    .RESET_PC(16'h0000),
    .PC_STEP (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: instruction word is address XOR 0x5A00, ack after wait_n stall cycles.
  assign mem_rdata = mem_addr ^ 16'h5A00;
  assign mem_ack   = force_ack || (mem_req && (wcnt >= wait_n));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    force_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wait_n = 0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_instr !== 16'h0000) begin errors++; $display("FAIL rst_out_instr: got %h want 0000", out_instr); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL rst_out_pc: got %h want 0000", out_pc); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    rst_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lat_req_edge1: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL lat_addr_edge1: got %h want 0000", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_edge1: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid_edge2: got %b want 1", out_valid); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL lat_pc_edge2: got %h want 0000", out_pc); end
    checks++; if (out_instr !== 16'h5A00) begin errors++; $display("FAIL lat_instr_edge2: got %h want 5a00", out_instr); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_pc = 16'(2 * k);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, out_pc, exp_pc); end
      checks++; if (out_instr !== (exp_pc ^ 16'h5A00)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", k, out_instr, exp_pc ^ 16'h5A00); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc;
    wait_n = 0;
    out_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_full_occ: got %0d want 4", occupancy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %b want 0", mem_req); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL bp_full_head: got %h want 0000", out_pc); end
    repeat (2) tick();
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_hold_occ: got %0d want 4", occupancy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_hold_req: got %b want 0", mem_req); end
    out_ready = 1'b1;
    tick();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL bp_rel_occ: got %0d want 3", occupancy); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL bp_rel_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 16'h0008) begin errors++; $display("FAIL bp_rel_addr: got %h want 0008", mem_addr); end
    checks++; if (out_pc !== 16'h0002) begin errors++; $display("FAIL bp_rel_head: got %h want 0002", out_pc); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      exp_pc = 16'(2 * k);
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", k, out_pc, exp_pc); end
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    wait_n = 3;
    out_ready = 1'b1;
    do_reset();
    n = 0;
    while (!(mem_req && mem_addr == 16'h0004) && n < 40) begin
      tick();
      n++;
    end
    checks++; if (!(mem_req === 1'b1 && mem_addr === 16'h0004)) begin errors++; $display("FAIL rw_reach_req4: got req=%b addr=%h want req=1 addr=0004", mem_req, mem_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rw_flush_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 16'h0004) begin errors++; $display("FAIL rw_flush_addr: got %h want 0004", mem_addr); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rw_flush_occ: got %0d want 0", occupancy); end
    n = 0;
    while (mem_req && n < 20) begin
      tick();
      n++;
      checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rw_flush_empty[%0d]: got occ=%0d valid=%b want 0/0", n, occupancy, out_valid); end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL rw_hold_cycles: got %0d want 3", n); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL rw_new_req: got req=%b addr=%h want 1/0100", mem_req, mem_addr); end
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rw_new_latency: got %0d want 4", n); end
    checks++; if (out_pc !== 16'h0100) begin errors++; $display("FAIL rw_new_pc: got %h want 0100", out_pc); end
    checks++; if (out_instr !== 16'h5B00) begin errors++; $display("FAIL rw_new_instr: got %h want 5b00", out_instr); end
  endtask

  task automatic test_redirect_ack_pop();
    wait_n = 0;
    out_ready = 1'b1;
    do_reset();
    repeat (4) tick();
    checks++; if (mem_ack !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rap_setup: got ack=%b valid=%b want 1/1", mem_ack, out_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rap_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rap_occ: got %0d want 0", occupancy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rap_req_idle: got %b want 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL rap_new_req: got req=%b addr=%h want 1/0040", mem_req, mem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0040) begin errors++; $display("FAIL rap_new_head: got valid=%b pc=%h want 1/0040", out_valid, out_pc); end
    checks++; if (out_instr !== 16'h5A40) begin errors++; $display("FAIL rap_new_instr: got %h want 5a40", out_instr); end
  endtask

  task automatic test_wrap();
    wait_n = 0;
    out_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    checks++; if (out_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc0: got %h want fffe", out_pc); end
    tick();
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc1: got %h want 0000", out_pc); end
    checks++; if (out_instr !== 16'h5A00) begin errors++; $display("FAIL wrap_instr1: got %h want 5a00", out_instr); end
    tick();
    checks++; if (out_pc !== 16'h0002) begin errors++; $display("FAIL wrap_pc2: got %h want 0002", out_pc); end
  endtask

  task automatic test_async_reset();
    wait_n = 0;
    out_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    wait_n = 20;
    repeat (2) tick();
    checks++; if (mem_req !== 1'b1 || mem_addr === 16'h0000) begin errors++; $display("FAIL ar_setup: got req=%b addr=%h want 1/nonzero", mem_req, mem_addr); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ar_req_drop: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL ar_addr: got %h want 0000", mem_addr); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL ar_occ: got %0d want 0", occupancy); end
    force_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    force_ack = 1'b0;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_stray_ack: got occ=%0d valid=%b want 0/0", occupancy, out_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL ar_restart_req: got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    wait_n = 0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin errors++; $display("FAIL ar_restart_head: got valid=%b pc=%h want 1/0000", out_valid, out_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wait_n = 0;
    force_ack = 1'b0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
